// File: rtl/fifo_puerto_if.sv
// Push/pop port bundle of the per-port transaction FIFO.
// The slave side is the FIFO; the master side is the producer/arbiter.
interface fifo_puerto_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  valid_out;
  logic                  empty;
  logic                  full;
  logic                  almostfull;
  logic                  almostempty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error_out;

  modport master (
    output push, data_in, pop,
    input  data_out, valid_out, empty, full,
    input  almostfull, almostempty, count, error_out
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, valid_out, empty, full,
    output almostfull, almostempty, count, error_out
  );
endinterface

// File: rtl/fifo_puerto.sv
// Per-port synchronous FIFO with occupancy flags and sticky error.
// Depth 2^ADDR_WIDTH, registered read data, no fall-through.
module fifo_puerto #(
  parameter int DATA_WIDTH  = 10,
  parameter int ADDR_WIDTH  = 3,
  parameter int UMBRAL_ALTO = 6,
  parameter int UMBRAL_BAJO = 2
) (
  input logic        clk,
  input logic        reset,
  fifo_puerto_if.slave port
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CW    = ADDR_WIDTH + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         count_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  valid_q;
  logic                  err_q;
  logic                  is_empty;
  logic                  is_full;
  logic                  do_push;
  logic                  do_pop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign do_pop   = port.pop && !is_empty;
  // A full FIFO still takes a push when the same edge frees a slot.
  assign do_push  = port.push && (!is_full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= port.data_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      dout_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout_q <= mem[rd_ptr];
      end
      valid_q <= do_pop;
      if (do_push && !do_pop) begin
        count_q <= count_q + 1'b1;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - 1'b1;
      end
      if ((port.push && !do_push) ||
          (port.pop && !do_pop)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign port.data_out    = dout_q;
  assign port.valid_out   = valid_q;
  assign port.count       = count_q;
  assign port.empty       = is_empty;
  assign port.full        = is_full;
  assign port.almostfull  = (count_q >= CW'(UMBRAL_ALTO));
  assign port.almostempty = (count_q <= CW'(UMBRAL_BAJO));
  assign port.error_out   = err_q;
endmodule

// File: tb/tb_fifo_puerto.sv
// Bench for fifo_puerto: queue model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_fifo_puerto;
  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;

  fifo_puerto_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) bus ();

  fifo_puerto #(
    .DATA_WIDTH(10),
    .ADDR_WIDTH(3),
    .UMBRAL_ALTO(6),
    .UMBRAL_BAJO(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .port(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [9:0] q [$];
  logic [9:0] m_dout;
  logic       m_valid;
  logic       m_err;

  // Reference: a queue of words, popped before pushed on each edge.
  always @(posedge clk or posedge reset) begin
    bit pop_ok;
    bit push_ok;
    if (reset) begin
      q.delete();
      m_dout  = '0;
      m_valid = 1'b0;
      m_err   = 1'b0;
    end else begin
      pop_ok  = bus.pop && (q.size() > 0);
      push_ok = bus.push && ((q.size() < 8) || pop_ok);
      if (pop_ok) m_dout = q.pop_front();
      m_valid = pop_ok;
      if (push_ok) q.push_back(bus.data_in);
      if ((bus.push && !push_ok) || (bus.pop && !pop_ok))
        m_err = 1'b1;
    end
  end

  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t",
               name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (n_tests >= 0 && !$isunknown(reset)) begin
      chk("m.count", int'(bus.count), q.size());
      chk("m.empty", int'(bus.empty), int'(q.size() == 0));
      chk("m.full", int'(bus.full), int'(q.size() == 8));
      chk("m.afull", int'(bus.almostfull), int'(q.size() >= 6));
      chk("m.aempty", int'(bus.almostempty), int'(q.size() <= 2));
      chk("m.valid", int'(bus.valid_out), int'(m_valid));
      chk("m.err", int'(bus.error_out), int'(m_err));
      chk("m.dout", int'(bus.data_out), int'(m_dout));
    end
  end

  task automatic cyc(bit ps, logic [9:0] d, bit pp);
    bus.push    = ps;
    bus.data_in = d;
    bus.pop     = pp;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    #1;
    chk("rst.count", int'(bus.count), 0);
    chk("rst.empty", int'(bus.empty), 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = '0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("init.empty", int'(bus.empty), 1);
    chk("init.aempty", int'(bus.almostempty), 1);
    chk("init.count", int'(bus.count), 0);
    chk("init.err", int'(bus.error_out), 0);
    chk("init.dout", int'(bus.data_out), 0);
    cyc(0, 0, 0);

    // mid-stream async reset with five words held
    for (int i = 0; i < 5; i++) cyc(1, 10'(i + 'h40), 0);
    chk("pre_rst.count", int'(bus.count), 5);
    do_reset();

    // basic ordering
    cyc(1, 10'h3A5, 0);
    cyc(1, 10'h1FF, 0);
    cyc(1, 10'h002, 0);
    cyc(0, 0, 1);
    chk("b.d0", int'(bus.data_out), 'h3A5);
    chk("b.v0", int'(bus.valid_out), 1);
    cyc(0, 0, 1);
    chk("b.d1", int'(bus.data_out), 'h1FF);
    cyc(0, 0, 1);
    chk("b.d2", int'(bus.data_out), 'h002);
    chk("b.v2", int'(bus.valid_out), 1);
    cyc(0, 0, 0);
    chk("b.vidle", int'(bus.valid_out), 0);
    chk("b.empty", int'(bus.empty), 1);

    // fill, overflow, drain
    for (int i = 0; i < 8; i++) begin
      cyc(1, 10'(i), 0);
      if (i == 4) chk("f.af5", int'(bus.almostfull), 0);
      if (i == 5) chk("f.af6", int'(bus.almostfull), 1);
      if (i == 6) chk("f.full7", int'(bus.full), 0);
      if (i == 7) chk("f.full8", int'(bus.full), 1);
    end
    cyc(1, 10'h0FF, 0);
    chk("f.err", int'(bus.error_out), 1);
    chk("f.count", int'(bus.count), 8);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 1);
      chk("f.drain", int'(bus.data_out), i);
    end
    chk("f.empty", int'(bus.empty), 1);
    do_reset();

    // push+pop while full: read-before-write
    for (int i = 0; i < 8; i++) cyc(1, 10'(i), 0);
    cyc(1, 10'h2AA, 1);
    chk("rbw.dout", int'(bus.data_out), 'h000);
    chk("rbw.count", int'(bus.count), 8);
    chk("rbw.err", int'(bus.error_out), 0);
    for (int i = 0; i < 8; i++) cyc(0, 0, 1);
    chk("rbw.last", int'(bus.data_out), 'h2AA);
    do_reset();

    // underflow and push+pop on empty
    cyc(1, 10'h155, 0);
    cyc(0, 0, 1);
    chk("u.first", int'(bus.data_out), 'h155);
    cyc(0, 0, 1);
    chk("u.err", int'(bus.error_out), 1);
    chk("u.valid", int'(bus.valid_out), 0);
    chk("u.hold", int'(bus.data_out), 'h155);
    cyc(1, 10'h0AB, 1);
    chk("u.count", int'(bus.count), 1);
    chk("u.nofall", int'(bus.valid_out), 0);
    cyc(0, 0, 1);
    chk("u.read", int'(bus.data_out), 'h0AB);
    do_reset();

    // wrap-around with steady occupancy of three
    for (int i = 0; i < 3; i++) cyc(1, 10'('h100 + i), 0);
    for (int i = 0; i < 20; i++) begin
      cyc(1, 10'('h103 + i), 1);
      chk("w.dout", int'(bus.data_out), 'h100 + i);
      chk("w.count", int'(bus.count), 3);
    end
    chk("w.err", int'(bus.error_out), 0);
    cyc(0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
